// File: rtl/modmul_interleaved_if.sv
//------------------------------------------------------------------------------
// Module   : modmul_interleaved_if
// Brief    : Request/result bundle between the exponentiation controller
//            and the bit-serial modular multiplier.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface modmul_interleaved_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] n;
   logic         busy;
   logic         done;
   logic [N-1:0] p;

   modport master (
      output start, a, b, n,
      input  busy, done, p
   );

   modport slave (
      input  start, a, b, n,
      output busy, done, p
   );
endinterface

`default_nettype wire

// File: rtl/modmul_interleaved.sv
//------------------------------------------------------------------------------
// Module   : modmul_interleaved
// Brief    : Bit-serial interleaved modular multiplier, p = (a*b) mod n,
//            one bit of b (MSB first) per cycle, N cycles per request.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module modmul_interleaved #(
   parameter int N = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   modmul_interleaved_if.slave   bus
);

   localparam int c_IW = $clog2(N);
   localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   logic [N:0]      r_acc;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_n;
   logic [c_IW-1:0] r_idx;
   logic [N-1:0]    r_p;
   logic            r_busy;
   logic            r_done;

   logic [N:0]      w_nx;
   logic [N:0]      w_dbl;
   logic [N:0]      w_red1;
   logic [N:0]      w_add;
   logic [N:0]      w_red2;
   logic            w_degen;
   logic [N-1:0]    w_result;

   // One interleaved step; R < n <= 2^N keeps 2R and R+a within N+1 bits.
   assign w_nx     = {1'b0, r_n};
   assign w_dbl    = r_acc << 1;
   assign w_red1   = (w_dbl >= w_nx) ? (w_dbl - w_nx) : w_dbl;
   assign w_add    = r_b[N-1] ? (w_red1 + {1'b0, r_a}) : w_red1;
   assign w_red2   = (w_add >= w_nx) ? (w_add - w_nx) : w_add;

   // n = 0 or 1 would leave the reductions ineffective, so force the result.
   assign w_degen  = ~|r_n[N-1:1];
   assign w_result = w_degen ? '0 : w_red2[N-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_n     <= '0;
         r_idx   <= '0;
         r_p     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_n     <= bus.n;
                  r_acc   <= '0;
                  r_idx   <= c_LAST;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= w_red2;
               r_b   <= r_b << 1;
               r_idx <= r_idx - 1'b1;
               if (r_idx == '0) begin
                  r_p     <= w_result;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.p    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_modmul_interleaved.sv
//------------------------------------------------------------------------------
// Module   : tb_modmul_interleaved
// Brief    : Self-checking bench for modmul_interleaved (N = 8).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_modmul_interleaved;

   localparam int N = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;
   logic [N-1:0] prev_p;
   bit   p_known;

   modmul_interleaved_if #(.N(N)) bus ();

   modmul_interleaved #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [N-1:0] ref_mulmod(input logic [N-1:0] x, input logic [N-1:0] y,
                                                input logic [N-1:0] m);
      longint unsigned prod;
      if (m < 2) return '0;
      prod = longint'(x) * longint'(y);
      return N'(prod % longint'(m));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Single request; chk_p=0 for operands whose result is unspecified.
   task automatic run_req(input logic [N-1:0] ta, input logic [N-1:0] tbv, input logic [N-1:0] tn,
                          input logic [N-1:0] exp, input bit chk_p, input bit poke,
                          input string tag);
      int cnt, busyc, extra;
      bit pmove;
      @(negedge clk);
      bus.start = 1'b1; bus.a = ta; bus.b = tbv; bus.n = tn;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = N'($urandom); bus.b = N'($urandom); bus.n = N'($urandom);
      busyc = bus.busy ? 1 : 0;
      cnt = 0; pmove = 0;
      for (int c = 1; c <= 4*N; c++) begin
         if (poke && c == 3) begin bus.start = 1'b1; bus.a = ~ta; bus.b = ~tbv; end
         if (poke && c == 4) bus.start = 1'b0;
         @(posedge clk); #1;
         cnt = c;
         if (bus.done) break;
         if (bus.busy) busyc++;
         if (p_known && bus.p !== prev_p) pmove = 1;
      end
      check({tag, "_latency"}, cnt, N);
      check({tag, "_busy_cycles"}, busyc, N);
      check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 0);
      check({tag, "_p_held"}, {31'd0, pmove}, 0);
      if (chk_p) begin
         check({tag, "_p"}, bus.p, exp);
         prev_p = exp; p_known = 1;
      end else begin
         p_known = 0;
      end
      @(posedge clk); #1;
      check({tag, "_done_width"}, {31'd0, bus.done}, 0);
      if (poke) begin
         extra = 0;
         for (int c = 0; c < N + 3; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) extra++;
         end
         check({tag, "_no_second_req"}, extra, 0);
      end
   endtask

   // Back-to-back chain with start held high; opmask bit k: 1 = multiply by base, 0 = square.
   task automatic run_chain(input logic [N-1:0] base, input logic [N-1:0] tn, input int nops,
                            input logic [7:0] opmask, input logic [N-1:0] final_exp,
                            input string tag);
      logic [N-1:0] x, ea, eb, exp;
      int cnt;
      x = base;
      @(negedge clk);
      bus.start = 1'b1; bus.n = tn;
      bus.a = x; bus.b = opmask[0] ? base : x;
      @(posedge clk); #1;
      for (int k = 0; k < nops; k++) begin
         ea = bus.a; eb = bus.b;
         exp = ref_mulmod(ea, eb, tn);
         cnt = 0;
         for (int c = 1; c <= 4*N; c++) begin
            @(posedge clk); #1;
            cnt = c;
            if (bus.done) break;
         end
         check($sformatf("%s_step%0d_spacing", tag, k), cnt, (k == 0) ? N : N + 1);
         check($sformatf("%s_step%0d_p", tag, k), bus.p, exp);
         x = exp;
         if (k < nops - 1) begin
            bus.a = x; bus.b = opmask[k+1] ? base : x;
         end else begin
            bus.start = 1'b0;
         end
      end
      check({tag, "_final"}, bus.p, final_exp);
      prev_p = x; p_known = 1;
      @(posedge clk); #1;
      check({tag, "_idle_after"}, {30'd0, bus.done, bus.busy}, 0);
   endtask

   initial begin
      logic [N-1:0] ra, rb, rn;
      int spurious;
      n_checks = 0; n_err = 0;
      prev_p = '0; p_known = 1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.n = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_p", bus.p, 0);
      check("reset_busy", {31'd0, bus.busy}, 0);
      check("reset_done", {31'd0, bus.done}, 0);
      @(negedge clk);
      rst = 1'b1;

      run_req(8'd106, 8'd106, 8'd221, 8'd186, 1, 0, "sq106");
      run_req(8'd220, 8'd220, 8'd221, 8'd1,   1, 0, "sq220");
      run_req(8'd0,   8'd200, 8'd221, 8'd0,   1, 0, "zero_a");
      run_req(8'd1,   8'd173, 8'd221, 8'd173, 1, 0, "one_a");
      run_req(8'd254, 8'd254, 8'd255, 8'd1,   1, 0, "top_bit");
      run_req(8'd5,   8'd7,   8'd0,   8'd0,   1, 0, "n_zero");
      run_req(8'd9,   8'd9,   8'd200, 8'd81,  1, 0, "plain");
      run_req(8'd0,   8'd0,   8'd1,   8'd0,   1, 0, "n_one");
      run_req(8'd250, 8'd251, 8'd100, 8'd0,   0, 0, "out_of_range");

      for (int i = 0; i < 16; i++) begin
         rn = N'($urandom_range(255, 2));
         ra = N'($urandom_range(int'(rn) - 1, 0));
         rb = N'($urandom_range(int'(rn) - 1, 0));
         run_req(ra, rb, rn, ref_mulmod(ra, rb, rn), 1, 0, $sformatf("rand%0d", i));
      end

      run_chain(8'd106, 8'd221, 5, 8'b0001_0010, 8'd106, "chain_plan");
      run_chain(8'd106, 8'd221, 5, 8'b0001_0100, 8'd98,  "chain_pow11");

      run_req(8'd106, 8'd106, 8'd221, 8'd186, 1, 1, "start_in_run");

      // Abort mid-request with an asynchronous reset between clock edges.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'd106; bus.b = 8'd106; bus.n = 8'd221;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("abort_p", bus.p, 0);
      check("abort_busy", {31'd0, bus.busy}, 0);
      check("abort_done", {31'd0, bus.done}, 0);
      @(negedge clk);
      rst = 1'b1;
      spurious = 0;
      for (int c = 0; c < 3*N; c++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) spurious++;
      end
      check("abort_no_done", spurious, 0);
      prev_p = '0; p_known = 1;
      run_req(8'd106, 8'd106, 8'd221, 8'd186, 1, 0, "after_abort");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
